// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared types and constants for the exhaustive 3-input sweep checker
package sweep_pkg;

  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = 3;
  localparam int HOLD_W      = 8;

  // Truth table of the checked block: bit i is the expected output for {a,b,c} = i
  localparam logic [NUM_VECTORS-1:0] DEFAULT_EXPECTED = 8'b0011_1001;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    FINISH
  } state_t;

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - loadable down-counter timing how long each vector settles
module hold_timer
  import sweep_pkg::*;
#(
  parameter int W = HOLD_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         expired
);

  // Load has priority; the count saturates at zero rather than wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/sweep_checker.sv
// rtl/sweep_checker.sv - drives all 8 input vectors to a 3-input block and grades its output
module sweep_checker
  import sweep_pkg::*;
#(
  parameter int                     HOLD_CYCLES = 4,
  parameter logic [NUM_VECTORS-1:0] EXPECTED    = DEFAULT_EXPECTED
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   dut_out,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] err_mask
);

  // DRIVE lasts reload+1 cycles and SAMPLE one more, so each vector is held HOLD_CYCLES
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 2);
  localparam logic [VEC_W-1:0]  LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

  state_t                   state;
  logic [VEC_W-1:0]         idx;
  logic                     mismatch;
  logic [NUM_VECTORS-1:0]   sampled_mask;
  logic                     tmr_load;
  logic                     tmr_dec;
  logic                     tmr_expired;
  logic [HOLD_W-1:0]        hold_left_unused;

  // Compare the settled response with the golden table and fold it into the mask
  always_comb begin
    mismatch     = (dut_out != EXPECTED[idx]);
    sampled_mask = err_mask;
    if (mismatch) begin
      sampled_mask[idx] = 1'b1;
    end
  end

  // Arm the timer whenever a new vector starts being driven
  always_comb begin
    tmr_load = ((state == IDLE) && start) || ((state == SAMPLE) && (idx != LAST_VEC));
    tmr_dec  = (state == DRIVE);
  end

  hold_timer #(
    .W(HOLD_W)
  ) u_hold_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (HOLD_RELOAD),
    .dec      (tmr_dec),
    .count    (hold_left_unused),
    .expired  (tmr_expired)
  );

  // Sweep sequencer; every output is a register updated here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_mask <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err_mask <= '0;
            idx      <= '0;
            pass     <= 1'b0;
            busy     <= 1'b1;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (tmr_expired) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          err_mask <= sampled_mask;
          if (idx == LAST_VEC) begin
            // The final sample is folded in here so pass is valid alongside done
            pass  <= (sampled_mask == '0);
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            idx   <= idx + 1'b1;
            state <= DRIVE;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign a = idx[2];
  assign b = idx[1];
  assign c = idx[0];

endmodule

// File: tb/tb_sweep_checker.sv
// tb/tb_sweep_checker.sv - randomized self-checking bench for sweep_checker
module tb_sweep_checker;
  import sweep_pkg::*;

  localparam logic [7:0] EXP = DEFAULT_EXPECTED;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       start0, start1;
  logic       dout0, dout1;
  logic       a0, b0, c0, busy0, done0, pass0;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [7:0] em0, em1;
  logic [7:0] exp_v;
  logic [7:0] flip [2];
  logic [2:0] idx0, idx1;

  int total  = 0;
  int passed = 0;

  sweep_checker #(.HOLD_CYCLES(4), .EXPECTED(EXP)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .dut_out(dout0),
    .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0), .err_mask(em0)
  );

  sweep_checker #(.HOLD_CYCLES(2), .EXPECTED(EXP)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .dut_out(dout1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1), .err_mask(em1)
  );

  // Checked logic blocks: golden truth table with selected vectors inverted
  assign exp_v = EXP;
  assign idx0  = {a0, b0, c0};
  assign idx1  = {a1, b1, c1};
  assign dout0 = exp_v[idx0] ^ flip[0][idx0];
  assign dout1 = exp_v[idx1] ^ flip[1][idx1];

  function automatic int hval(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic logic [13:0] got_of(input int k);
    if (k == 0) return {idx0, busy0, done0, pass0, em0};
    return {idx1, busy1, done1, pass1, em1};
  endfunction

  task automatic set_start(input int k, input logic v);
    if (k == 0) start0 = v;
    else        start1 = v;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
  endtask

  // Behavioural model: a sweep is a timeline of cycles 1..8H+1 after the accepted start
  bit         run_m [2];
  int         t_m   [2];
  logic [7:0] fl_m  [2];
  logic [7:0] hm_m  [2];
  bit         hp_m  [2];
  int         hi_m  [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        run_m[k] = 0; t_m[k] = 0; hm_m[k] = '0; hp_m[k] = 0; hi_m[k] = 0;
      end else if (run_m[k]) begin
        t_m[k]++;
        if (t_m[k] > 8 * hval(k) + 1) begin
          run_m[k] = 0;
          hm_m[k]  = fl_m[k];
          hp_m[k]  = (fl_m[k] == 8'h00);
          hi_m[k]  = 7;
        end
      end else if ((k == 0) ? start0 : start1) begin
        run_m[k] = 1;
        t_m[k]   = 1;
        fl_m[k]  = flip[k];
      end
    end
  end

  // Per-cycle comparison of every output of both instances against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int         h, t, vi;
      logic [7:0] m;
      bit         bz, dn, p;
      h = hval(k);
      t = t_m[k];
      if (run_m[k]) begin
        vi = (t <= 8 * h) ? (t - 1) / h : 7;
        bz = 1;
        dn = (t == 8 * h + 1);
        m  = '0;
        for (int v = 0; v < 8; v++)
          if ((v + 1) * h + 1 <= t) m[v] = fl_m[k][v];
        p = dn ? (m == 8'h00) : 1'b0;
      end else begin
        vi = hi_m[k]; bz = 0; dn = 0; m = hm_m[k]; p = hp_m[k];
      end
      check($sformatf("cycle_u%0d", k), {2'b00, got_of(k)}, {2'b00, 3'(vi), bz, dn, p, m});
    end
  end

  // One sweep on instance k; returns after the done cycle, or after a reset abort
  task automatic sweep(input int k, input logic [7:0] f, input int restart_at,
                       input int reset_at, input bit noise, input int want_c,
                       input logic [7:0] want_mask, input bit want_pass);
    int  c, h;
    bit  seen, aborted, seq_ok;
    logic [13:0] g;
    h = hval(k);
    @(negedge clk); #2;
    flip[k] = f;
    set_start(k, 1'b1);
    @(negedge clk); #2;
    set_start(k, 1'b0);
    c = 1; seen = 0; aborted = 0; seq_ok = 1;
    while (!seen && !aborted && c < 8 * h + 40) begin
      g = got_of(k);
      if (c <= 8 * h && g[13:11] != 3'((c - 1) / h)) seq_ok = 0;
      if (g[9]) begin
        seen = 1;
      end else if (c == reset_at) begin
        reset_n = 1'b0;
        #1;
        check("reset_zero_u0", {2'b00, got_of(0)}, 16'h0000);
        check("reset_zero_u1", {2'b00, got_of(1)}, 16'h0000);
        aborted = 1;
        @(negedge clk); #2;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
      end else begin
        set_start(k, (c == restart_at) || (noise && $urandom_range(0, 3) == 0));
        @(negedge clk); #2;
        c++;
      end
    end
    if (seen) begin
      check($sformatf("done_cycle_u%0d", k), 16'(c), 16'(want_c));
      check($sformatf("err_mask_u%0d", k), {8'h00, g[7:0]}, {8'h00, want_mask});
      check($sformatf("pass_u%0d", k), {15'h0, g[8]}, {15'h0, want_pass});
      check($sformatf("abc_seq_u%0d", k), {15'h0, seq_ok}, 16'h0001);
      set_start(k, noise ? 1'b1 : 1'b0);
      @(negedge clk); #2;
      set_start(k, 1'b0);
    end else if (!aborted) begin
      check($sformatf("done_timeout_u%0d", k), 16'(c), 16'(want_c));
    end
  endtask

  initial begin
    logic [7:0] r;
    reset_n = 1'b0;
    start0  = 1'b0;
    start1  = 1'b0;
    flip[0] = '0;
    flip[1] = '0;
    repeat (3) @(negedge clk);
    #2;
    check("por_u0", {2'b00, got_of(0)}, 16'h0000);
    check("por_u1", {2'b00, got_of(1)}, 16'h0000);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    sweep(0, 8'h00, 0, 0, 0, 33, 8'h00, 1'b1);
    sweep(0, EXP,   0, 0, 0, 33, 8'h39, 1'b0);
    sweep(0, 8'h40, 0, 0, 0, 33, 8'h40, 1'b0);
    sweep(0, 8'h00, 10, 0, 0, 33, 8'h00, 1'b1);
    sweep(0, 8'h00, 0, 15, 0, 33, 8'h00, 1'b1);
    sweep(0, 8'h00, 0, 0, 0, 33, 8'h00, 1'b1);
    sweep(1, 8'h00, 0, 0, 0, 17, 8'h00, 1'b1);

    for (int n = 0; n < 8; n++) begin
      r = 8'($urandom);
      if (n == 2) r = 8'h80;
      if (n == 3) r = 8'h01;
      sweep(n % 2, r, 0, 0, 1, 8 * hval(n % 2) + 1, r, r == 8'h00);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
